// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the writeback unit.
// Load-type funct3 encodings and the hold-buffer state enum.
package wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/load_align.sv
// load_align: extracts the addressed byte/half from a raw memory word and
// sign- or zero-extends it according to the load funct3. Purely combinational.
module load_align
  import wb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_rdata,
  input  logic [2:0]   i_funct3,
  input  logic [1:0]   i_addr_lo,
  output logic [N-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte/half, then extend per load type
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    case (i_funct3)
      LB:      o_data = {{(N-8){w_byte[7]}}, w_byte};
      LBU:     o_data = {{(N-8){1'b0}}, w_byte};
      LH:      o_data = {{(N-16){w_half[15]}}, w_half};
      LHU:     o_data = {{(N-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_writer.sv
// wb_writer: drives the register file's single write port, merging ALU
// results (priority) with formatted load responses held in a one-entry buffer.
// Optional macro WB_SCOREBOARD_EN adds a pending-load scoreboard and the
// read-after-load stall output; without it stall is tied low.
module wb_writer
  import wb_pkg::*;
#(
  parameter int N          = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_valid,
  input  logic [4:0]   alu_rd,
  input  logic [N-1:0] alu_data,
  input  logic         ld_issue,
  input  logic [4:0]   ld_rd,
  input  logic         mem_valid,
  output logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  input  logic [2:0]   mem_funct3,
  input  logic [1:0]   mem_addr_lo,
  input  logic [4:0]   mem_rd,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  output logic         stall,
  output logic         alu_stall,
  output logic         Wr_en,
  output logic [4:0]   rd,
  output logic [N-1:0] Wr_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  hold_state_e  r_state, w_state_nxt;
  logic [N-1:0] r_hold_data;
  logic [4:0]   r_hold_rd;
  logic [N-1:0] w_ld_fmt;
  logic         w_accept, w_drain, w_blocked;
  logic         r_wr_en, w_wr_en;
  logic [4:0]   r_rd, w_rd;
  logic [N-1:0] r_wr_data, w_wr_data;
  logic [CW-1:0] r_starve;
  logic         r_alu_stall;

  load_align #(.N(N)) u_load_align (
    .i_rdata   (mem_rdata),
    .i_funct3  (mem_funct3),
    .i_addr_lo (mem_addr_lo),
    .o_data    (w_ld_fmt)
  );

  assign mem_ready = (r_state == EMPTY);
  assign w_accept  = mem_valid & mem_ready;
  assign w_drain   = (r_state == HELD) & ~alu_valid;
  assign w_blocked = (r_state == HELD) & alu_valid;
  assign Wr_en     = r_wr_en;
  assign rd        = r_rd;
  assign Wr_data   = r_wr_data;
  assign alu_stall = r_alu_stall;

  // Hold-buffer next state: fill on accept, empty when the held entry wins
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = HELD;
      HELD:    if (w_drain)  w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Hold-buffer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Capture the already-formatted load response on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_data <= '0;
      r_hold_rd   <= '0;
    end else if (w_accept) begin
      r_hold_data <= w_ld_fmt;
      r_hold_rd   <= mem_rd;
    end
  end

  // Write-port arbitration: ALU first, otherwise the held load; x0 never written
  always_comb begin
    w_wr_en   = 1'b0;
    w_rd      = '0;
    w_wr_data = '0;
    if (alu_valid) begin
      w_wr_en   = (alu_rd != 5'd0);
      w_rd      = alu_rd;
      w_wr_data = alu_data;
    end else if (r_state == HELD) begin
      w_wr_en   = (r_hold_rd != 5'd0);
      w_rd      = r_hold_rd;
      w_wr_data = r_hold_data;
    end
  end

  // Registered register-file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_rd      <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= w_wr_en;
      r_rd      <= w_rd;
      r_wr_data <= w_wr_data;
    end
  end

  // Starvation counter: saturates at STARVE_MAX, cleared when the hold drains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve    <= '0;
      r_alu_stall <= 1'b0;
    end else if (w_drain) begin
      r_starve    <= '0;
      r_alu_stall <= 1'b0;
    end else if (w_blocked && (r_starve != CW'(STARVE_MAX))) begin
      r_starve <= r_starve + CW'(1);
      if (r_starve + CW'(1) == CW'(STARVE_MAX)) r_alu_stall <= 1'b1;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] r_pending, w_pending_nxt;
  logic        r_ld_wb;

  // Flags that the current write-port slot carries a load (clears its bit)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ld_wb <= 1'b0;
    else      r_ld_wb <= w_drain;
  end

  // Clear on load writeback, then set on issue so set wins; x0 never pending
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_ld_wb) w_pending_nxt[r_rd] = 1'b0;
    if (ld_issue && (ld_rd != 5'd0)) w_pending_nxt[ld_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= w_pending_nxt;
  end

  assign stall = r_pending[rs1] | r_pending[rs2];
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{ld_issue, ld_rd, rs1, rs2};
  assign stall       = 1'b0;
`endif

endmodule

// File: doc/wb_writer.md
# wb_writer

Writeback unit that drives the register file's single write port. It merges single-cycle ALU results with load responses from the data-memory side. Load data is byte/half/word aligned and extended, and held in a one-entry buffer when the write port is busy. An optional scoreboard tracks outstanding load destinations so decode can stall on read-after-load hazards. It sits between the execute/memory stages and the register file.

## Interface
- N, 32, data width
- STARVE_MAX, 4, cycles a held load may lose arbitration before `alu_stall` asserts (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; never back-pressured
- alu_rd  in  5  ALU destination
- alu_data  in  N  ALU result
- ld_issue  in  1  load issued this cycle (scoreboard set)
- ld_rd  in  5  destination of issued load
- mem_valid  in  1  load response valid
- mem_ready  out  1  unit can accept a load response; equals !hold_valid
- mem_rdata  in  N  raw aligned memory word
- mem_funct3  in  3  load type
- mem_addr_lo  in  2  byte offset
- mem_rd  in  5  load destination
- rs1, rs2  in  5 each  decode source registers for hazard check
- stall  out  1  combinational: pending[rs1] | pending[rs2]
- alu_stall  out  1  registered; upstream must not present alu_valid next cycle
- Wr_en  out  1  register-file write enable
- rd  out  5  register-file write address
- Wr_data  out  N  register-file write data

## Operation
- Hold buffer states: EMPTY and HELD.
- EMPTY→HELD on mem_valid & mem_ready; captured data is already formatted.
- HELD→EMPTY when the held entry wins the write port.
- Write-port arbitration each cycle: ALU has priority when alu_valid is high; otherwise the held entry is written.
- A response accepted while EMPTY is written through the hold buffer, never directly.
- Load formatting, funct3:
  - 000 LB: byte[addr_lo], sign-extended.
  - 100 LBU: byte[addr_lo], zero-extended.
  - 001 LH: half[addr_lo[1]], sign-extended.
  - 101 LHU: half[addr_lo[1]], zero-extended.
  - 010 LW and all other codes: raw word.
- rd==0: Wr_en is driven 0 for that slot. The entry is still consumed and still clears the scoreboard.
- Starvation counter:
  - Increments each cycle the unit is HELD and alu_valid is high.
  - alu_stall sets when the count reaches STARVE_MAX.
  - Counter and alu_stall clear the cycle the hold drains.
- If alu_valid arrives despite alu_stall, the ALU still wins; the protocol violation is not masked.
- Scoreboard, 32 bits:
  - ld_issue with ld_rd≠0 sets bit ld_rd.
  - Load writeback clears bit mem_rd.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.

## Timing
- Reset: Wr_en=0, rd=0, Wr_data=0, alu_stall=0, hold EMPTY, counter=0, scoreboard=0. mem_ready=1 once rst deasserts.
- Wr_en/rd/Wr_data are registered. alu_valid at cycle t gives Wr_en high in cycle t+1, and the register file commits at the end of t+1.
- Load accepted at t, no ALU contention: hold at t+1, Wr_en at t+2, scoreboard bit clears at end of t+2.
- mem_ready drops the cycle after acceptance and returns the cycle after the drain write.
- stall reflects the scoreboard contents registered at the current edge. A clear in cycle t removes the stall from t+1.
- Reset asserted mid-operation: the held entry is discarded and the pending bits are lost. The surrounding pipeline is reset together with this unit.

## Configuration
- WB_SCOREBOARD_EN defined: scoreboard and stall are implemented as above.
- WB_SCOREBOARD_EN undefined: no scoreboard flops, stall tied 0, ld_issue/ld_rd/rs1/rs2 ignored. All other behaviour is identical.

## Structure
- Package wb_pkg holds:
  - funct3 load constants (LB, LH, LW, LBU, LHU).
  - Hold-state enum (EMPTY, HELD).
- Sub-module load_align: combinational funct3/addr_lo extraction and extension, N-bit in/out. Instantiated once, ahead of the hold register.

## Test plan
- ALU only: alu_valid, alu_rd=5, alu_data=0xDEADBEEF → Wr_en=1, rd=5, Wr_data=0xDEADBEEF one cycle later; alu_rd=0 → Wr_en stays 0.
- Load formatting: mem_rdata=0x80FF7F01, mem_funct3=000, addr_lo=1 → 0x0000007F. funct3=001, addr_lo=2 → 0xFFFF80FF. funct3=101, addr_lo=2 → 0x000080FF.
- Contention: a load to x7 accepted while alu_valid stays high 6 cycles with STARVE_MAX=4 →
  - mem_ready=0 during the hold.
  - alu_stall rises after 4 blocked cycles.
  - The load writes x7 in the first cycle with alu_valid=0, then alu_stall clears.
- Scoreboard: ld_issue ld_rd=9, then rs1=9 → stall=1 until the x9 writeback, stall=0 next cycle. Simultaneous issue and writeback of x9 → bit stays set.
- Reset mid-hold: HELD entry, assert rst → Wr_en=0, mem_ready=1 after release, scoreboard=0, no stale write.
- With WB_SCOREBOARD_EN undefined: the same scoreboard stimulus gives stall=0 throughout.
